// File: rtl/data_checker_pkg.sv
// Shared PRBS constants and checker state type used by data_checker and prbs_lfsr.
// The same constants feed Data_Generator so transmit and receive patterns cannot diverge.
package data_checker_pkg;

  localparam int             PRBS_WIDTH = 9;
  localparam logic [8:0]     PRBS_TAPS  = 9'h110;  // x^9 + x^5 + 1
  localparam logic [8:0]     PRBS_SEED  = 9'h1FF;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_FINISH = 2'd3
  } chk_state_t;

endpackage

// File: rtl/prbs_lfsr.sv
// Fibonacci PRBS generator: BIT_OUT is the MSB, the register shifts left by one on EN.
// LOAD reseeds and wins over EN; the same block sits inside Data_Generator.
module prbs_lfsr #(
  parameter int                 WIDTH = 9,
  parameter logic [WIDTH-1:0]   TAPS  = 9'h110,
  parameter logic [WIDTH-1:0]   SEED  = 9'h1FF
) (
  input  logic CLK,
  input  logic RESET,
  input  logic LOAD,
  input  logic EN,
  output logic BIT_OUT
);

  logic [WIDTH-1:0] lfsr;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      lfsr <= SEED;
    end else if (LOAD) begin
      lfsr <= SEED;
    end else if (EN) begin
      lfsr <= {lfsr[WIDTH-2:0], ^(lfsr & TAPS)};
    end
  end

  assign BIT_OUT = lfsr[WIDTH-1];

endmodule

// File: rtl/data_checker.sv
// Receive-side PRBS checker: reads a 1-bit FIFO (read latency 1) and compares against a local LFSR.
// Optional first-error capture is enabled with `define DATA_CHECKER_FIRST_ERR_EN.
//
// FIFO handshake: FIFO_IN_RE is only raised while FIFO_IN_EMPTY is low; the bit on
// FIFO_IN_DATA is valid in the cycle after an RE (tracked by rd_pend).
module data_checker
  import data_checker_pkg::*;
#(
  parameter int                      BITS_NUMB  = 200,
  parameter int                      LFSR_WIDTH = PRBS_WIDTH,
  parameter logic [LFSR_WIDTH-1:0]   LFSR_TAPS  = PRBS_TAPS,
  parameter logic [LFSR_WIDTH-1:0]   LFSR_SEED  = PRBS_SEED,
  parameter int                      CNT_W      = $clog2(BITS_NUMB + 1)
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             START,
  input  logic             FIFO_IN_DATA,
  output logic             FIFO_IN_RE,
  input  logic             FIFO_IN_EMPTY,
  output logic [CNT_W-1:0] BIT_COUNT,
  output logic [CNT_W-1:0] ERR_COUNT,
  output logic             DONE,
  output logic             PASS,
`ifdef DATA_CHECKER_FIRST_ERR_EN
  output logic [CNT_W-1:0] FIRST_ERR_IDX,
  output logic             FIRST_ERR_VLD,
`endif
  output chk_state_t       state_dbg
);

  localparam logic [CNT_W-1:0] BITS_LIM  = CNT_W'(BITS_NUMB);
  localparam logic [CNT_W-1:0] LAST_READ = CNT_W'(BITS_NUMB - 1);

  chk_state_t       state, state_nx;
  logic [CNT_W-1:0] rd_cnt;
  logic [CNT_W-1:0] bit_cnt;
  logic [CNT_W-1:0] err_cnt;
  logic             rd_pend;
  logic             start_acc;
  logic             re;
  logic             exp_bit;
  logic             mismatch;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    re        = 1'b0;
    start_acc = 1'b0;
    case (state)
      ST_IDLE: begin
        if (START) begin
          start_acc = 1'b1;
          state_nx  = ST_RUN;
        end
      end
      ST_RUN: begin
        re = !FIFO_IN_EMPTY && (rd_cnt < BITS_LIM);
        if (re && (rd_cnt == LAST_READ)) begin
          state_nx = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        // The final read was issued on the way in; its data lands this cycle.
        if (rd_pend) begin
          state_nx = ST_FINISH;
        end
      end
      ST_FINISH: begin
        if (START) begin
          start_acc = 1'b1;
          state_nx  = ST_RUN;
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  assign mismatch = rd_pend && (FIFO_IN_DATA != exp_bit);

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      rd_cnt  <= '0;
      rd_pend <= 1'b0;
      bit_cnt <= '0;
      err_cnt <= '0;
    end else if (start_acc) begin
      rd_cnt  <= '0;
      rd_pend <= 1'b0;
      bit_cnt <= '0;
      err_cnt <= '0;
    end else begin
      rd_pend <= re;
      if (re) begin
        rd_cnt <= rd_cnt + CNT_W'(1);
      end
      if (rd_pend) begin
        bit_cnt <= bit_cnt + CNT_W'(1);
      end
      if (mismatch) begin
        err_cnt <= err_cnt + CNT_W'(1);
      end
    end
  end

  // Expected bit advances only on data-valid cycles, so EMPTY stalls keep alignment.
  prbs_lfsr #(
    .WIDTH (LFSR_WIDTH),
    .TAPS  (LFSR_TAPS),
    .SEED  (LFSR_SEED)
  ) u_prbs (
    .CLK     (CLK),
    .RESET   (RESET),
    .LOAD    (start_acc),
    .EN      (rd_pend),
    .BIT_OUT (exp_bit)
  );

`ifdef DATA_CHECKER_FIRST_ERR_EN
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      FIRST_ERR_IDX <= '0;
      FIRST_ERR_VLD <= 1'b0;
    end else if (start_acc) begin
      FIRST_ERR_IDX <= '0;
      FIRST_ERR_VLD <= 1'b0;
    end else if (mismatch && !FIRST_ERR_VLD) begin
      FIRST_ERR_IDX <= bit_cnt;
      FIRST_ERR_VLD <= 1'b1;
    end
  end
`endif

  assign FIFO_IN_RE = re;
  assign BIT_COUNT  = bit_cnt;
  assign ERR_COUNT  = err_cnt;
  assign DONE       = (state == ST_FINISH);
  assign PASS       = DONE && (err_cnt == '0);
  assign state_dbg  = state;

endmodule

// File: tb/tb_data_checker.sv
// Directed bench for data_checker: a behavioural PRBS source feeds a 16-deep 1-bit FIFO model.
// Covers clean, error-injected, bursty, overfill, mid-run reset and restart scenarios.
module tb_data_checker;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       fifo_dout;
  logic       fifo_empty;
  logic       fifo_re;
  logic [7:0] bit_count;
  logic [7:0] err_count;
  logic       done;
  logic       pass;
`ifdef DATA_CHECKER_FIRST_ERR_EN
  logic [7:0] first_err_idx;
  logic       first_err_vld;
`endif
  data_checker_pkg::chk_state_t state_dbg;

  data_checker dut (
    .CLK           (clk),
    .RESET         (rst_n),
    .START         (start),
    .FIFO_IN_DATA  (fifo_dout),
    .FIFO_IN_RE    (fifo_re),
    .FIFO_IN_EMPTY (fifo_empty),
    .BIT_COUNT     (bit_count),
    .ERR_COUNT     (err_count),
    .DONE          (done),
    .PASS          (pass),
`ifdef DATA_CHECKER_FIRST_ERR_EN
    .FIRST_ERR_IDX (first_err_idx),
    .FIRST_ERR_VLD (first_err_vld),
`endif
    .state_dbg     (state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // source + FIFO model (all state owned by this block)
  logic       fifo_q[$];
  logic [8:0] gen_lfsr;
  int         gen_idx;
  int         gen_total;
  int         wr_pct;
  logic       gen_on;
  logic       inj_en;
  logic       clr;
  int         re_pulses;
  int         re_empty;

  always @(posedge clk) begin
    logic b;
    if (clr) begin
      fifo_q.delete();
      gen_lfsr  = 9'h1FF;
      gen_idx   = 0;
      re_pulses = 0;
      re_empty  = 0;
      fifo_empty <= 1'b1;
      fifo_dout  <= 1'b0;
    end else begin
      if (gen_on && gen_idx < gen_total && fifo_q.size() < 16 &&
          $urandom_range(0, 99) < wr_pct) begin
        b        = gen_lfsr[8];
        gen_lfsr = {gen_lfsr[7:0], gen_lfsr[8] ^ gen_lfsr[4]};
        if (inj_en && (gen_idx == 5 || gen_idx == 17)) b = ~b;
        fifo_q.push_back(b);
        gen_idx++;
      end
      if (fifo_re) begin
        re_pulses++;
        if (fifo_empty) re_empty++;
        else fifo_dout <= fifo_q.pop_front();
      end
      fifo_empty <= (fifo_q.size() == 0);
    end
  end

  // scoreboard counters
  int total;
  int bad;

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // driver tasks
  task automatic start_run(input int n, input int pct, input logic inj);
    @(negedge clk);
    gen_on = 1'b0;
    clr    = 1'b1;
    @(negedge clk);
    clr       = 1'b0;
    gen_total = n;
    wr_pct    = pct;
    inj_en    = inj;
    gen_on    = 1'b1;
    start     = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    while (!done && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("done_reached", int'(done), 1);
  endtask

  task automatic check_final(input string tag, input int errs);
    chk({tag, "_bits"}, int'(bit_count), 200);
    chk({tag, "_errs"}, int'(err_count), errs);
    chk({tag, "_pass"}, int'(pass), (errs == 0) ? 1 : 0);
    chk({tag, "_re_pulses"}, re_pulses, 200);
    chk({tag, "_re_while_empty"}, re_empty, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    int n;
    total = 0; bad = 0;
    rst_n = 1'b0; start = 1'b0; gen_on = 1'b0; inj_en = 1'b0;
    clr = 1'b1; gen_total = 0; wr_pct = 100;
    repeat (3) @(negedge clk);
    chk("rst_bits", int'(bit_count), 0);
    chk("rst_errs", int'(err_count), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_pass", int'(pass), 0);
    chk("rst_re", int'(fifo_re), 0);
    rst_n = 1'b1;
    clr   = 1'b0;
    repeat (2) @(negedge clk);
    chk("idle_no_re", int'(fifo_re), 0);

    // clean loop
    start_run(200, 100, 1'b0);
    wait_done(3000);
    check_final("clean", 0);
    repeat (10) @(negedge clk);
    chk("clean_done_sticky", int'(done), 1);
    chk("clean_bits_held", int'(bit_count), 200);

    // restart after PASS: counters clear right after START is taken
    start_run(200, 100, 1'b0);
    chk("restart_bits_clr", int'(bit_count), 0);
    chk("restart_done_clr", int'(done), 0);
    wait_done(3000);
    check_final("restart", 0);

    // error injection at source bits 5 and 17
    start_run(200, 100, 1'b1);
    wait_done(3000);
    check_final("inject", 2);
    chk("inject_done", int'(done), 1);
`ifdef DATA_CHECKER_FIRST_ERR_EN
    chk("inject_first_idx", int'(first_err_idx), 5);
    chk("inject_first_vld", int'(first_err_vld), 1);
`endif

    // bursty source; START held high well into RUN is ignored
    start_run(200, 50, 1'b0);
    start = 1'b1;
    repeat (20) @(negedge clk);
    chk("bursty_still_running", int'(done), 0);
    start = 1'b0;
    wait_done(5000);
    check_final("bursty", 0);

    // overfill: 210 written, exactly 200 read, 10 left behind
    start_run(210, 100, 1'b0);
    wait_done(3000);
    n = 0;
    while (gen_idx < 210 && n < 500) begin
      @(negedge clk);
      n++;
    end
    repeat (5) @(negedge clk);
    check_final("overfill", 0);
    chk("overfill_left", fifo_q.size(), 10);

    // reset mid-run after 80 compared bits
    start_run(200, 100, 1'b0);
    n = 0;
    while (bit_count < 80 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("midrun_reached_80", (bit_count >= 80) ? 1 : 0, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("midrun_rst_bits", int'(bit_count), 0);
    chk("midrun_rst_errs", int'(err_count), 0);
    chk("midrun_rst_re", int'(fifo_re), 0);
    chk("midrun_rst_done", int'(done), 0);
    @(negedge clk);
    rst_n = 1'b1;
    start_run(200, 100, 1'b0);
    wait_done(3000);
    check_final("after_reset", 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
